// File: rtl/init_multi.sv
// S-array initialiser: writes DEPTH words into every enabled bank in parallel,
// one shared address/data word per cycle, with ascending, descending or constant data.
module init_multi #(
  parameter  int DEPTH     = 256,
  parameter  int DATA_W    = 8,
  parameter  int NUM_BANKS = 4,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [DATA_W-1:0]    fill,
  input  logic [NUM_BANKS-1:0] bank_mask,
  input  logic                 abort,
  output logic                 rdy,
  output logic                 done,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    wrdata,
  output logic [NUM_BANKS-1:0] wren
);

  // state  | meaning
  // S_IDLE | waiting for en; addr/wrdata hold the last written word
  // S_FILL | one write per cycle to every bank in the latched mask
  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  localparam logic [1:0]        MODE_CONST = 2'b01;
  localparam logic [1:0]        MODE_DESC  = 2'b10;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_W-1:0]      r_count;
  logic [1:0]             r_mode;
  logic [DATA_W-1:0]      r_fill;
  logic [NUM_BANKS-1:0]   r_mask;
  logic                   r_done;

  logic                   w_idle;
  logic                   w_start;
  logic                   w_desc;
  logic                   w_last;
  logic [DATA_W-1:0]      w_cnt_data;

  assign w_idle  = (r_state == S_IDLE);
  assign w_start = w_idle && en && (bank_mask != '0);
  assign w_desc  = (r_mode == MODE_DESC);
  assign w_last  = w_desc ? (r_count == '0) : (r_count == LAST_ADDR);

  // Identity data is the address zero-extended or truncated to the word width.
  generate
    if (DATA_W > ADDR_W) begin : g_cnt_ext
      assign w_cnt_data = {{(DATA_W - ADDR_W){1'b0}}, r_count};
    end else if (DATA_W == ADDR_W) begin : g_cnt_eq
      assign w_cnt_data = r_count;
    end else begin : g_cnt_trunc
      assign w_cnt_data = r_count[DATA_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (abort || w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The count holds when leaving FILL so addr/wrdata keep the last written word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_mode  <= '0;
      r_fill  <= '0;
      r_mask  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_idle) begin
        if (en) begin
          if (bank_mask != '0) begin
            r_mode  <= mode;
            r_fill  <= fill;
            r_mask  <= bank_mask;
            r_count <= (mode == MODE_DESC) ? LAST_ADDR : '0;
          end else begin
            r_done <= 1'b1;
          end
        end
      end else begin
        if (!abort) begin
          if (w_last) begin
            r_done <= 1'b1;
          end else if (w_desc) begin
            r_count <= r_count - ADDR_W'(1);
          end else begin
            r_count <= r_count + ADDR_W'(1);
          end
        end
      end
    end
  end

  assign rdy    = w_idle;
  assign done   = r_done;
  assign addr   = r_count;
  assign wrdata = (r_mode == MODE_CONST) ? r_fill : w_cnt_data;
  assign wren   = w_idle ? '0 : r_mask;

endmodule

// File: tb/tb_init_multi.sv
// Bench for init_multi: instance A (256x8) and instance B (200x16), both four banks,
// checked every cycle against a pending-write list model plus directed literal checks.
module tb_init_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        chk_on;
  logic        en_i[2];
  logic [1:0]  mode_i[2];
  logic [15:0] fill_i[2];
  logic [3:0]  mask_i[2];
  logic        abort_i[2];

  logic        rdy_a, done_a, rdy_b, done_b;
  logic [7:0]  addr_a, addr_b;
  logic [7:0]  wd_a;
  logic [15:0] wd_b;
  logic [3:0]  wren_a, wren_b;

  init_multi u_a (
    .clk(clk), .rst_n(rst_n), .en(en_i[0]), .mode(mode_i[0]), .fill(fill_i[0][7:0]),
    .bank_mask(mask_i[0]), .abort(abort_i[0]), .rdy(rdy_a), .done(done_a),
    .addr(addr_a), .wrdata(wd_a), .wren(wren_a)
  );

  init_multi #(.DEPTH(200), .DATA_W(16), .NUM_BANKS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_i[1]), .mode(mode_i[1]), .fill(fill_i[1]),
    .bank_mask(mask_i[1]), .abort(abort_i[1]), .rdy(rdy_b), .done(done_b),
    .addr(addr_b), .wrdata(wd_b), .wren(wren_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted request expands into the list of writes it must produce.
  int          depth_k[2] = '{256, 200};
  logic [15:0] dmask_k[2] = '{16'h00FF, 16'hFFFF};
  int          pend_addr[2][256];
  logic [15:0] pend_data[2][256];
  int          head[2] = '{0, 0};
  int          len[2] = '{0, 0};
  logic [3:0]  m_mask[2];
  logic        m_done[2];
  int          m_la[2] = '{0, 0};
  logic [15:0] m_ld[2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        len[k] = 0; head[k] = 0; m_mask[k] = 4'h0; m_done[k] = 1'b0;
        m_la[k] = 0; m_ld[k] = 16'h0;
      end else if (len[k] != 0) begin
        m_la[k] = pend_addr[k][head[k]];
        m_ld[k] = pend_data[k][head[k]];
        head[k]++;
        len[k]--;
        if (abort_i[k] === 1'b1) begin
          len[k] = 0;
          m_done[k] = 1'b0;
        end else begin
          m_done[k] = (len[k] == 0);
        end
      end else begin
        m_done[k] = 1'b0;
        if (en_i[k] === 1'b1) begin
          if (mask_i[k] != 4'h0) begin
            m_mask[k] = mask_i[k];
            head[k] = 0;
            len[k] = depth_k[k];
            for (int j = 0; j < depth_k[k]; j++) begin
              pend_addr[k][j] = (mode_i[k] == 2'b10) ? depth_k[k] - 1 - j : j;
              pend_data[k][j] = (mode_i[k] == 2'b01) ? (fill_i[k] & dmask_k[k])
                                                     : (16'(pend_addr[k][j]) & dmask_k[k]);
            end
          end else begin
            m_done[k] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        logic        busy;
        logic [31:0] e_addr, e_data;
        logic        a_rdy, a_done;
        logic [3:0]  a_wren;
        logic [7:0]  a_addr;
        logic [15:0] a_data;
        busy   = (len[k] != 0);
        e_addr = busy ? 32'(pend_addr[k][head[k]]) : 32'(m_la[k]);
        e_data = busy ? 32'(pend_data[k][head[k]]) : 32'(m_ld[k]);
        a_rdy  = (k == 0) ? rdy_a  : rdy_b;
        a_done = (k == 0) ? done_a : done_b;
        a_wren = (k == 0) ? wren_a : wren_b;
        a_addr = (k == 0) ? addr_a : addr_b;
        a_data = (k == 0) ? {8'h00, wd_a} : wd_b;
        check($sformatf("model_rdy%0d", k),  32'(a_rdy),  32'(!busy));
        check($sformatf("model_done%0d", k), 32'(a_done), 32'(m_done[k]));
        check($sformatf("model_wren%0d", k), 32'(a_wren), busy ? 32'(m_mask[k]) : 32'h0);
        check($sformatf("model_addr%0d", k), 32'(a_addr), e_addr);
        check($sformatf("model_data%0d", k), 32'(a_data), e_data);
      end
    end
  end

  // Shadow of bank contents for instance A, captured by the stimulus process.
  logic       wfl[4][256];
  logic [7:0] sh[4][256];
  int         done_a_cnt;
  int         wr_cyc_a;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (wren_a != 4'h0) wr_cyc_a++;
    for (int b = 0; b < 4; b++) begin
      if (wren_a[b]) begin
        wfl[b][addr_a] = 1'b1;
        sh[b][addr_a] = wd_a;
      end
    end
    if (done_a) done_a_cnt++;
  endtask

  task automatic clear_a();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 256; i++) begin
        wfl[b][i] = 1'b0;
        sh[b][i] = 8'h00;
      end
    end
    done_a_cnt = 0;
    wr_cyc_a = 0;
  endtask

  task automatic start_a(input logic [1:0] m, input logic [7:0] f, input logic [3:0] msk);
    clear_a();
    mode_i[0] = m; fill_i[0] = {8'h00, f}; mask_i[0] = msk; en_i[0] = 1'b1;
    step();
    en_i[0] = 1'b0;
  endtask

  task automatic run_to_addr_a(input int target, input string nm);
    int n = 0;
    while (!(wren_a != 4'h0 && addr_a == 8'(target)) && n < 300) begin
      step();
      n++;
    end
    check(nm, 32'(addr_a), 32'(target));
  endtask

  int errs, bmax, bdone, bidle;
  logic [15:0] blast;

  initial begin
    rst_n = 1'b1;
    chk_on = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en_i[k] = 1'b0; mode_i[k] = 2'b00; fill_i[k] = 16'h0; mask_i[k] = 4'h0; abort_i[k] = 1'b0;
    end
    clear_a();
    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    check("rst_rdy_a", 32'(rdy_a), 32'd1);
    check("rst_wren_a", 32'(wren_a), 32'd0);
    check("rst_addr_b", 32'(addr_b), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Ascending identity into all banks; inputs changed mid-fill must be ignored.
    start_a(2'b00, 8'h00, 4'hF);
    mode_i[0] = 2'b10; mask_i[0] = 4'h1;
    repeat (256) step();
    check("t1_done", 32'(done_a), 32'd1);
    check("t1_rdy_at_done", 32'(rdy_a), 32'd1);
    check("t1_done_count", 32'(done_a_cnt), 32'd1);
    check("t1_write_cycles", 32'(wr_cyc_a), 32'd256);
    errs = 0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 256; i++)
        if (!wfl[b][i] || sh[b][i] != 8'(i)) errs++;
    check("t1_readback_errs", 32'(errs), 32'd0);

    // Descending identity into banks 0 and 2.
    start_a(2'b10, 8'h00, 4'b0101);
    check("t2_first_addr", 32'(addr_a), 32'd255);
    check("t2_first_data", 32'(wd_a), 32'd255);
    repeat (256) step();
    check("t2_done_count", 32'(done_a_cnt), 32'd1);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (!wfl[0][i] || sh[0][i] != 8'(i)) errs++;
      if (!wfl[2][i] || sh[2][i] != 8'(i)) errs++;
      if (wfl[1][i] || wfl[3][i]) errs++;
    end
    check("t2_readback_errs", 32'(errs), 32'd0);

    // Constant fill aborted while addr=17 is being written.
    start_a(2'b01, 8'hA5, 4'hF);
    run_to_addr_a(17, "t3_reach_17");
    abort_i[0] = 1'b1;
    step();
    abort_i[0] = 1'b0;
    check("t3_wren_after_abort", 32'(wren_a), 32'd0);
    check("t3_rdy_after_abort", 32'(rdy_a), 32'd1);
    repeat (5) step();
    check("t3_done_count", 32'(done_a_cnt), 32'd0);
    check("t3_write_cycles", 32'(wr_cyc_a), 32'd18);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if ((i <= 17) != wfl[0][i] || (i <= 17 && sh[0][i] != 8'hA5)) errs++;
    check("t3_written_range_errs", 32'(errs), 32'd0);

    // Mode 11 runs ascending; abort coinciding with the last write suppresses done.
    start_a(2'b11, 8'h00, 4'b1000);
    run_to_addr_a(255, "t4_reach_255");
    abort_i[0] = 1'b1;
    step();
    abort_i[0] = 1'b0;
    check("t4_done_on_abort_last", 32'(done_a), 32'd0);
    repeat (3) step();
    check("t4_done_count", 32'(done_a_cnt), 32'd0);
    check("t4_write_cycles", 32'(wr_cyc_a), 32'd256);

    // Empty mask: accepted, no writes, done next cycle.
    start_a(2'b00, 8'h00, 4'h0);
    check("t5_done", 32'(done_a), 32'd1);
    check("t5_wren", 32'(wren_a), 32'd0);
    step();
    check("t5_done_drops", 32'(done_a), 32'd0);
    check("t5_write_cycles", 32'(wr_cyc_a), 32'd0);

    // Reset asserted mid-fill at addr=100.
    start_a(2'b00, 8'h00, 4'hF);
    run_to_addr_a(100, "t6_reach_100");
    done_a_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_wren_async", 32'(wren_a), 32'd0);
    check("t6_rdy_async", 32'(rdy_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    check("t6_done_count", 32'(done_a_cnt), 32'd0);

    // Instance B: en held high, fills run back to back with one done cycle between.
    mode_i[1] = 2'b00; mask_i[1] = 4'hF; en_i[1] = 1'b1;
    bmax = 0; bdone = 0; bidle = 0; blast = 16'h0;
    for (int s = 0; s < 402; s++) begin
      step();
      if (wren_b != 4'h0) begin
        if (int'(addr_b) > bmax) bmax = int'(addr_b);
        if (addr_b == 8'd199) blast = wd_b;
      end else begin
        bidle++;
      end
      if (done_b) bdone++;
    end
    check("t7_max_addr", 32'(bmax), 32'd199);
    check("t7_last_data", 32'(blast), 32'h00C7);
    check("t7_done_count", 32'(bdone), 32'd2);
    check("t7_idle_cycles", 32'(bidle), 32'd2);
    step();
    check("t7_no_gap_wren", 32'(wren_b), 32'hF);
    check("t7_no_gap_addr", 32'(addr_b), 32'd0);
    en_i[1] = 1'b0;
    abort_i[1] = 1'b1;
    step();
    abort_i[1] = 1'b0;
    step();
    check("t7_idle_after_abort", 32'(rdy_b), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/init_multi.md
Name: init_multi

Overview:
- Parametrised S-array initialiser for the parallel crack datapath.
- Fills up to NUM_BANKS single-port memories, one word per cycle. All enabled banks get the same address and data. Each bank has its own write enable.
- Supports identity-ascending, constant-fill and identity-descending modes, an abort input, and a one-cycle done pulse. Sits between the top-level controller and the per-core S memories, ahead of the KSA phase.

Parameters:
DEPTH, 256, number of words per bank; legal range 2..65536
DATA_W, 8, memory word width
NUM_BANKS, 4, number of memory banks driven in parallel; legal range 1..64
ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
en  in  1  start request; sampled only while rdy=1
mode  in  2  00 identity ascending, 01 constant fill, 10 identity descending, 11 treated as 00
fill  in  DATA_W  constant for mode 01; latched on accept
bank_mask  in  NUM_BANKS  bit i=1 enables writes to bank i; latched on accept
abort  in  1  stop an in-progress fill
rdy  out  1  block idle, will accept en
done  out  1  one-cycle pulse: fill completed normally
addr  out  ADDR_W  shared write address
wrdata  out  DATA_W  shared write data
wren  out  NUM_BANKS  per-bank write enable

Behaviour:
- States: IDLE, FILL.
- Reset (async assert, any state): state=IDLE, count=0, rdy=1, done=0, wren=0, addr=0, wrdata=0, latched mode/fill/mask=0.
- Outputs are registered or decoded from state/count only. No combinational path from en, mode, fill or bank_mask to any output.
- IDLE: rdy=1, wren=0.
  - On a clock edge with en=1 and bank_mask!=0: latch mode, fill and mask; go to FILL.
  - Starting count: 0 for modes 00, 01 and 11; DEPTH-1 for mode 10.
  - en=1 with bank_mask==0: accepted, no FILL, done=1 in the next cycle, stays IDLE.
- FILL: rdy=0, addr=count, wren=latched mask.
  - wrdata: count zero-extended (or truncated) to DATA_W for identity modes; latched fill for mode 01.
  - Count steps +1 each cycle (ascending modes) or -1 (mode 10).
  - After the cycle with count=DEPTH-1 (ascending) or count=0 (descending), go to IDLE and assert done=1 for exactly the first IDLE cycle.
  - Exactly DEPTH write cycles, every address written once. Latency from accepting edge to last write = DEPTH cycles.
  - Count never wraps. Non-power-of-2 DEPTH stops at DEPTH-1 and never emits addresses >= DEPTH.
- Back-to-back: en=1 during the done cycle (rdy=1) is accepted, so the next FILL starts with no gap.
- abort=1 in FILL: on the next edge, go to IDLE with wren=0 from that cycle and done=0. The write presented in the abort cycle still occurs. abort in IDLE is ignored.
- Simultaneous abort and last write: the final write completes and abort wins, so done=0.
- en and all inputs other than abort are ignored during FILL. Inputs changing mid-fill have no effect.
- Reset mid-FILL: immediate return to IDLE, wren=0 asynchronously. No done.
- In IDLE, addr and wrdata hold their last values; consumers must qualify with wren.

Test Plan:
- Reset then en=1, mode=00, mask=4'b1111, DEPTH=256 -> 256 cycles of wren=1111 with addr=wrdata=0..255 ascending. done pulses 1 cycle with rdy=1 in the same cycle. Each bank reads back S[i]=i.
- mode=10, mask=4'b0101 -> addr/wrdata 255..0 descending. wren=0101 throughout. Banks 1 and 3 are untouched.
- mode=01, fill=8'hA5, abort asserted on the cycle with addr=17 -> writes to addresses 0..17 occur, wren=0 from the next cycle, done never asserts, rdy=1.
- DEPTH=200, DATA_W=16, en held high continuously -> consecutive fills with no idle gap beyond the single done cycle. Max addr=199; wrdata=16'h00C7 at the last write.
- en=1 with mask=0 -> no wren, done pulses in the next cycle. Separately, rst_n dropped at addr=100 -> wren=0 immediately, rdy=1, no done after release.
